muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 122 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide unit for the EX stage: one shift-add or
// restoring-divide step per cycle, stalling the pipeline until the result lands.
module muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [WIDTH-1:0] ALU_Remainder,
    output logic             R15_write,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             op_q;
    logic [WIDTH-1:0] opd_q;   // multiplicand for mul, divisor for div
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] res_q, rem_q;
    logic             dbz_q;

    logic             accept, dz;
    logic [WIDTH:0]   sum, shl, diff;
    logic [WIDTH-1:0] hi_n, lo_n;

    assign accept = (state_q != BUSY) && start && !flush;
    assign dz     = op && (B == '0);

    // One iteration: mul shifts {carry,hi,lo} right, div shifts {hi,lo} left
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        shl  = {hi_q, lo_q[WIDTH-1]};
        diff = shl - {1'b0, opd_q};
        hi_n = hi_q;
        lo_n = lo_q;
        if (!op_q) begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            hi_n = diff[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_n = shl[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (flush)      state_d = IDLE;
                else if (start) state_d = dz ? DONE : BUSY;
                else            state_d = IDLE;
            end
            BUSY: begin
                if (flush)              state_d = IDLE;
                else if (cnt_q == LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            op_q  <= 1'b0;
            opd_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            res_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            cnt_q <= '0;
            op_q  <= op;
            opd_q <= op ? B : A;
            lo_q  <= op ? A : B;
            hi_q  <= '0;
            dbz_q <= dz;
            if (dz) begin
                res_q <= '1;
                rem_q <= A;
            end
        end else if (state_q == BUSY && !flush) begin
            cnt_q <= cnt_q + 1'b1;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            if (cnt_q == LAST) begin
                res_q <= lo_n;
                rem_q <= hi_n;
            end
        end
    end

    // A flush arriving in the DONE cycle squashes the writeback as well
    always_comb begin
        stall       = rst_n && ((state_q == IDLE && start && !flush) || state_q == BUSY);
        done        = (state_q == DONE) && !flush;
        R15_write   = done;
        div_by_zero = done && dbz_q;
    end

    assign ALU_Result    = res_q;
    assign ALU_Remainder = rem_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected results,
// a negedge monitor pops and checks them whenever done is presented.
module tb_muldiv_sequencer;
    logic        clk = 0, rst_n = 0, start = 0, op = 0, flush = 0;
    logic [15:0] A = 0, B = 0;
    logic        stall, done, R15_write, div_by_zero;
    logic [15:0] ALU_Result, ALU_Remainder;

    muldiv_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .stall(stall), .done(done), .ALU_Result(ALU_Result),
        .ALU_Remainder(ALU_Remainder), .R15_write(R15_write),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [15:0] rem;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int cyc = 0, pass_cnt = 0, tot_cnt = 0;
    logic [15:0] prev_res = 0, prev_rem = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_cycle", cyc, mon_e.due);
                chk("result", ALU_Result, mon_e.res);
                chk("remainder", ALU_Remainder, mon_e.rem);
                chk("div_by_zero", div_by_zero, mon_e.dbz);
                chk("r15_write", R15_write, 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one op, disturb inputs while busy, and measure stall length
    task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic [15:0] m, input logic z);
        int lat, nst;
        lat = z ? 1 : 17;
        exp_q.push_back('{r, m, z, cyc + lat});
        op = o; A = a; B = b; start = 1;
        nst = 0;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (stall) nst++;
            tick(1);
            start = (k == 3);
            A = 16'hDEAD; B = 16'h0000; op = 1;
        end
        start = 0;
        @(negedge clk);
        chk("stall_in_done", stall, 0);
        chk("stall_cycles", nst, lat);
        tick(1);
        chk("done_seen", exp_q.size(), 0);
        prev_res = r; prev_rem = m;
    endtask

    initial begin
        int c;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        start = 1;
        #3;
        chk("rst_stall", stall, 0);
        chk("rst_done", {done, R15_write, div_by_zero}, 0);
        chk("rst_result", {ALU_Result, ALU_Remainder}, 0);
        start = 0;
        tick(3);
        rst_n = 1;

        issue(0, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 0);
        issue(0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0);
        issue(1, 16'd100,  16'd7,    16'h000E, 16'h0002, 0);
        issue(1, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 1);
        issue(0, 16'h0000, 16'h5A5A, 16'h0000, 16'h0000, 0);
        issue(0, 16'd300,  16'd200,  16'hEA60, 16'h0000, 0);
        issue(1, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0);
        issue(1, 16'h1234, 16'hFFFF, 16'h0000, 16'h1234, 0);
        issue(0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0);

        // flush at count 5, then start+flush in IDLE
        start = 1; op = 0; A = 16'h1111; B = 16'h2222;
        tick(1);
        start = 0;
        tick(5);
        flush = 1;
        tick(1);
        flush = 0;
        chk("flush_stall", stall, 0);
        chk("flush_hold_res", {ALU_Result, ALU_Remainder}, {prev_res, prev_rem});
        start = 1; flush = 1;
        #1;
        chk("start_flush_stall", stall, 0);
        tick(1);
        start = 0; flush = 0;
        chk("start_flush_ignored", stall, 0);
        tick(20);
        chk("flush_no_result", {ALU_Result, ALU_Remainder}, {prev_res, prev_rem});

        // back-to-back: new start held in the DONE cycle
        c = cyc;
        exp_q.push_back('{16'h000E, 16'h0002, 1'b0, c + 17});
        start = 1; op = 1; A = 16'd100; B = 16'd7;
        tick(1);
        start = 0;
        tick(16);
        exp_q.push_back('{16'h0003, 16'h0000, 1'b0, c + 34});
        start = 1; op = 1; A = 16'd9; B = 16'd3;
        tick(1);
        start = 0;
        chk("b2b_busy_stall", stall, 1);
        tick(18);
        chk("b2b_done_seen", exp_q.size(), 0);

        // reset at BUSY count 8
        start = 1; op = 0; A = 16'h00FF; B = 16'h0101;
        tick(1);
        start = 0;
        tick(8);
        #2 rst_n = 0;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_flags", {done, R15_write, div_by_zero}, 0);
        chk("midrst_result", {ALU_Result, ALU_Remainder}, 0);
        tick(1);
        rst_n = 1;
        tick(25);
        chk("midrst_no_done", {ALU_Result, ALU_Remainder}, 0);
        issue(0, 16'h00FF, 16'h0101, 16'hFFFF, 16'h0000, 0);

        tick(2);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
